axi_lite_master_bridge: RTL
===========================

// Module: axi_lite_master_bridge
// PURPOSE
// - Initiator end of the single-beat AXI4-Lite bus used by LSIC and the other memory-mapped peripherals.
// - Converts a simple CPU load/store request port into one AXI read or write transaction, then returns data/status on a response port.
// - One transaction outstanding at a time; no bursts, no reordering.
// - Sits between the CPU data port and the peripheral interconnect.
// PARAMETERS
// - ADDR_W  32  AXI/request address width
// - DATA_W  32  AXI/request data width; wstrb width is DATA_W/8
// PORTS
// clk            in   1         clock
// rst_n          in   1         reset, asynchronous, active-low
// req_valid      in   1         request present
// req_ready      out  1         bridge accepts request (IDLE only)
// req_we         in   1         1=write, 0=read
// req_addr       in   ADDR_W    byte address, must be 4-byte aligned
// req_wdata      in   DATA_W    write data
// req_wstrb      in   DATA_W/8  write byte strobes
// rsp_valid      out  1         response present, held until rsp_ready
// rsp_ready      in   1         response consumed
// rsp_rdata      out  DATA_W    read data (0 for writes/misaligned)
// rsp_err        out  1         1 = SLVERR/DECERR/misaligned/missing rlast
// m_axi_awvalid  out  1         AW channel
// m_axi_awready  in   1
// m_axi_awaddr   out  ADDR_W
// m_axi_wvalid   out  1         W channel
// m_axi_wready   in   1
// m_axi_wdata    out  DATA_W
// m_axi_wstrb    out  DATA_W/8
// m_axi_bvalid   in   1         B channel
// m_axi_bready   out  1
// m_axi_bresp    in   2
// m_axi_arvalid  out  1         AR channel
// m_axi_arready  in   1
// m_axi_araddr   out  ADDR_W
// m_axi_rvalid   in   1         R channel
// m_axi_rlast    in   1
// m_axi_rready   out  1
// m_axi_rdata    in   DATA_W
// m_axi_rresp    in   2
// BEHAVIOUR
// - All outputs registered. On rst_n low, asynchronously: state=IDLE and every valid/ready output=0, including req_ready.
//   Addr/data/strb outputs=0; rsp_rdata=0, rsp_err=0. First cycle after release: req_ready=1.
// - Reset mid-transaction abandons it. The system resets slaves together with the bridge.
// - States: IDLE, WR (AW+W), WRESP, RD_A, RD_D, RSP.
//   - IDLE: req_ready=1. Accept when req_valid&&req_ready; latch addr/wdata/wstrb/we; req_ready->0.
//     - addr[1:0]!=0: go to RSP, err=1, rdata=0, no AXI traffic.
//     - Aligned write: go to WR with awvalid=wvalid=1 on the next cycle.
//     - Aligned read: go to RD_A with arvalid=1.
//   - WR: awvalid and wvalid drop independently on their own handshakes, which may occur in either order or the same cycle.
//     Once both are done: bready=1, go to WRESP. Valids never drop before their handshake; addr/data stable while valid.
//   - WRESP: on bvalid&&bready: bready->0; err=bresp[1]; rdata=0; go to RSP.
//   - RD_A: on arvalid&&arready: arvalid->0, rready=1, go to RD_D.
//   - RD_D: on rvalid&&rready: rready->0; latch rdata; err=rresp[1] | ~rlast; go to RSP.
//   - RSP: rsp_valid=1, rdata/err stable. On rsp_valid&&rsp_ready: rsp_valid->0, req_ready->1, go to IDLE.
// - Unused channels remain idle throughout: arvalid/rready=0 in a write, awvalid/wvalid/bready=0 in a read.
// - Latency with a zero-wait slave: accept (T) -> AW/W valid T+1 -> bready T+2 -> B T+2 -> rsp_valid T+3.
// - No timeout; a slave that never responds stalls the bridge until reset.
// - bresp/rresp OKAY(00) and EXOKAY(01) -> err=0; SLVERR(10) and DECERR(11) -> err=1.
// TESTING
// - Write 0xF8030014 data 5 strb F to LSIC-like slave -> AW/W beats addr 0xF8030014 data 5, bresp 00 -> rsp_err=0, rsp_rdata=0.
// - Slave holds wready=0 for 3 cycles after awready -> awvalid drops after its handshake, wvalid held 3 cycles, single B, one rsp.
// - Read 0xF8030010 from slave returning rdata 0x2A, rresp 00, rlast 1 -> rsp_rdata=0x2A, rsp_err=0.
// - Read 0xF8030018, slave returns rresp 11 -> rsp_err=1; read with rlast=0 and rresp 00 -> rsp_err=1.
// - req_addr 0xF8030006 -> no AXI valid ever asserted; rsp_valid 1 cycle later with err=1; rsp_ready held 0 for 4 cycles keeps rsp_valid and rsp_err stable.
// - rst_n pulsed low while awvalid=1 -> awvalid=0 immediately (async); after release req_ready=1, next write completes normally.

Source files
------------

// File: rtl/axi_lite_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_bridge_if
// Brief    : Bundles the CPU request/response port and the single-beat
//            AXI4-Lite initiator channels of axi_lite_master_bridge.
//            "master" is the bridge view. "slave" is the view of the
//            CPU plus interconnect that surround it.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    // CPU request port
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;

    // CPU response port
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    // AXI4-Lite write address / data / response
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [ADDR_W-1:0]     m_axi_awaddr;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [DATA_W/8-1:0]   m_axi_wstrb;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [1:0]            m_axi_bresp;

    // AXI4-Lite read address / data
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ADDR_W-1:0]     m_axi_araddr;
    logic                  m_axi_rvalid;
    logic                  m_axi_rlast;
    logic                  m_axi_rready;
    logic [DATA_W-1:0]     m_axi_rdata;
    logic [1:0]            m_axi_rresp;

    // Bridge side
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output m_axi_awvalid, m_axi_awaddr,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        input  m_axi_wready,
        input  m_axi_bvalid, m_axi_bresp,
        output m_axi_bready,
        output m_axi_arvalid, m_axi_araddr,
        input  m_axi_arready,
        input  m_axi_rvalid, m_axi_rlast, m_axi_rdata, m_axi_rresp,
        output m_axi_rready
    );

    // CPU + interconnect side
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  m_axi_awvalid, m_axi_awaddr,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
        output m_axi_wready,
        output m_axi_bvalid, m_axi_bresp,
        input  m_axi_bready,
        input  m_axi_arvalid, m_axi_araddr,
        output m_axi_arready,
        output m_axi_rvalid, m_axi_rlast, m_axi_rdata, m_axi_rresp,
        input  m_axi_rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master_bridge
// Brief    : Turns one CPU load/store request into one single-beat AXI4-Lite
//            read or write transaction. It returns data and status on a
//            response port. Only one transaction is outstanding at a time.
//            Every output comes straight from a flop.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire                          clk,
    input  wire                          rst_n,
    axi_lite_master_bridge_if.master     bus
);

    localparam int STRB_W = DATA_W / 8;

    // Transaction sequencer states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RD_A  = 3'd3;
    localparam logic [2:0] S_RD_D  = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    logic [2:0]          state_q,     state_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                awvalid_q,   awvalid_d;
    logic [ADDR_W-1:0]   awaddr_q,    awaddr_d;
    logic                wvalid_q,    wvalid_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
    logic                bready_q,    bready_d;
    logic                arvalid_q,   arvalid_d;
    logic [ADDR_W-1:0]   araddr_q,    araddr_d;
    logic                rready_q,    rready_d;

    logic                w_accept;
    logic                w_misaligned;
    logic                w_aw_done;
    logic                w_w_done;
    logic                w_unused_resp_lsb;

    // Only resp[1] separates OKAY/EXOKAY from SLVERR/DECERR
    assign w_unused_resp_lsb = bus.m_axi_bresp[0] ^ bus.m_axi_rresp[0];

    assign w_accept     = bus.req_valid && req_ready_q;
    assign w_misaligned = (bus.req_addr[1:0] != 2'b00);

    // A write-channel half is done when it already handshook earlier or
    // handshakes this cycle. AW and W may finish in either order.
    assign w_aw_done = !awvalid_q || bus.m_axi_awready;
    assign w_w_done  = !wvalid_q  || bus.m_axi_wready;

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        rready_d    = rready_q;

        case (state_q)
            S_IDLE: begin
                // req_ready comes up the first cycle after reset release
                req_ready_d = 1'b1;
                if (w_accept) begin
                    req_ready_d = 1'b0;
                    if (w_misaligned) begin
                        // Fail locally without touching the bus
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (bus.req_we) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        awaddr_d  = bus.req_addr;
                        wvalid_d  = 1'b1;
                        wdata_d   = bus.req_wdata;
                        wstrb_d   = bus.req_wstrb;
                    end else begin
                        state_d   = S_RD_A;
                        arvalid_d = 1'b1;
                        araddr_d  = bus.req_addr;
                    end
                end
            end

            S_WR: begin
                if (awvalid_q && bus.m_axi_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && bus.m_axi_wready) begin
                    wvalid_d = 1'b0;
                end
                if (w_aw_done && w_w_done) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end

            S_WRESP: begin
                if (bus.m_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_err_d   = bus.m_axi_bresp[1];
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end

            S_RD_A: begin
                if (arvalid_q && bus.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_D;
                end
            end

            S_RD_D: begin
                if (bus.m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = bus.m_axi_rdata;
                    // A single-beat read must close with rlast
                    rsp_err_d   = bus.m_axi_rresp[1] | ~bus.m_axi_rlast;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end

            S_RSP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                // Unreachable encodings fall back to a clean idle bus
                state_d     = S_IDLE;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            wvalid_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            wvalid_q    <= wvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            rready_q    <= rready_d;
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_err       = rsp_err_q;
    assign bus.m_axi_awvalid = awvalid_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_wvalid  = wvalid_q;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_bready  = bready_q;
    assign bus.m_axi_arvalid = arvalid_q;
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_rready  = rready_q;

endmodule
`default_nettype wire
